// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Port buses are flat vectors; the slice helpers give the low bit of a port's field.
package rf_pkg;

   // Register index that is hardwired to zero when ZERO_REG is enabled.
   localparam int ZERO_ADDR = 0;

   // Address width for a register file of the given depth (at least one bit).
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Low bit of address field for a port on a flat address bus.
   function automatic int addr_slice(input int port, input int aw);
      return port * aw;
   endfunction

   // Low bit of data field for a port on a flat data bus.
   function automatic int data_slice(input int port, input int wl);
      return port * wl;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard. Decode marks a destination busy at issue,
// writeback clears it on retirement. A new producer (set) outranks a retiring
// one (clear) on the same register in the same cycle.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter  int DEPTH    = 32,
   parameter  int NWR      = 1,
   parameter  int ZERO_REG = 1,
   localparam int AW       = addr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_addr,
   input  logic [NWR-1:0]    clr_en,
   input  logic [NWR*AW-1:0] clr_addr,
   output logic [DEPTH-1:0]  busy_vec
);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Next busy state: apply clears first, then the issue set so it overrides them.
   always_comb begin
      // NOTE: start from the held value so every path assigns busy_d and no latch is inferred.
      busy_d = busy_q;
      for (int j = 0; j < NWR; j++) begin
         if (clr_en[j]) begin
            busy_d[clr_addr[addr_slice(j, AW) +: AW]] = 1'b0;
         end
      end
      if (iss_en) begin
         busy_d[iss_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_d[ZERO_ADDR] = 1'b0;
      end
   end

   // Busy register with synchronous reset taking priority over set and clear.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values in the same step.
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file for the 5-stage core.
// Combinational reads with optional same-cycle write bypass, optional
// hardwired zero register, and a busy scoreboard for RAW hazard detection.
module regfile_mp
   import rf_pkg::*;
#(
   parameter  int DEPTH    = 32,
   parameter  int WL       = 32,
   parameter  int NRD      = 2,
   parameter  int NWR      = 1,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int AW       = addr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*WL-1:0] rd_data,
   output logic [NRD-1:0]    rd_busy,
   input  logic [NWR-1:0]    wr_en,
   input  logic [NWR*AW-1:0] wr_addr,
   input  logic [NWR*WL-1:0] wr_data,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_addr,
   output logic [DEPTH-1:0]  busy_vec
);

   logic [WL-1:0] mem_q [DEPTH];
   logic [WL-1:0] mem_d [DEPTH];

   // Next array contents: ports applied in index order so the highest port wins on a collision.
   always_comb begin
      mem_d = mem_q;
      for (int j = 0; j < NWR; j++) begin
         if (wr_en[j] &&
             !(ZERO_REG != 0 && wr_addr[addr_slice(j, AW) +: AW] == AW'(ZERO_ADDR))) begin
            mem_d[wr_addr[addr_slice(j, AW) +: AW]] = wr_data[data_slice(j, WL) +: WL];
         end
      end
   end

   // Register array; reset clears every word.
   always_ff @(posedge clk) begin
      // NOTE: the whole array is reset because pipeline state must be zero after reset;
      // this keeps it in flops rather than a RAM macro, which is intended at this size.
      if (rst) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   // Busy tracking: writeback ports retire producers, issue marks the new one.
   rf_scoreboard #(
      .DEPTH    (DEPTH),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .clr_en   (wr_en),
      .clr_addr (wr_addr),
      .busy_vec (busy_vec)
   );

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] ra;
      logic [WL-1:0] word;
      logic          hit;

      assign ra = rd_addr[addr_slice(i, AW) +: AW];

      // Read mux: stored word, overridden by a matching write this cycle; r0 forced to zero.
      always_comb begin
         word = mem_q[ra];
         hit  = 1'b0;
         if (BYPASS != 0) begin
            for (int j = 0; j < NWR; j++) begin
               if (wr_en[j] && wr_addr[addr_slice(j, AW) +: AW] == ra) begin
                  word = wr_data[data_slice(j, WL) +: WL];
                  hit  = 1'b1;
               end
            end
         end
         if (ZERO_REG != 0 && ra == AW'(ZERO_ADDR)) begin
            word = '0;
         end
      end

      assign rd_data[data_slice(i, WL) +: WL] = word;
      // A value arriving through the bypass this cycle is no longer a hazard.
      assign rd_busy[i] = busy_vec[ra] & ~hit;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances sharing stimulus.
//   dut_a: NWR=2, BYPASS=1, ZERO_REG=1
//   dut_b: NWR=1 (port 0 of the shared write bus), BYPASS=0, ZERO_REG=1
// Expected outputs are pushed when a cycle's inputs are driven and popped
// and compared on the falling edge, before the state-updating rising edge.
module tb_regfile_mp;

   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int WL    = 32;
   localparam int NRD   = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NRD*AW-1:0] rd_addr;
   logic [1:0]        wr_en;
   logic [2*AW-1:0]   wr_addr;
   logic [2*WL-1:0]   wr_data;
   logic              iss_en;
   logic [AW-1:0]     iss_addr;

   logic [NRD*WL-1:0] rd_data_a, rd_data_b;
   logic [NRD-1:0]    rd_busy_a, rd_busy_b;
   logic [DEPTH-1:0]  busy_vec_a, busy_vec_b;

   always #5 clk = ~clk;

   regfile_mp #(
      .DEPTH(DEPTH), .WL(WL), .NRD(NRD), .NWR(2), .ZERO_REG(1), .BYPASS(1)
   ) dut_a (
      .clk      (clk),
      .rst      (rst),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data_a),
      .rd_busy  (rd_busy_a),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .busy_vec (busy_vec_a)
   );

   regfile_mp #(
      .DEPTH(DEPTH), .WL(WL), .NRD(NRD), .NWR(1), .ZERO_REG(1), .BYPASS(0)
   ) dut_b (
      .clk      (clk),
      .rst      (rst),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data_b),
      .rd_busy  (rd_busy_b),
      .wr_en    (wr_en[0:0]),
      .wr_addr  (wr_addr[AW-1:0]),
      .wr_data  (wr_data[WL-1:0]),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .busy_vec (busy_vec_b)
   );

   typedef struct {
      logic [NRD*WL-1:0] rd_data_a;
      logic [NRD*WL-1:0] rd_data_b;
      logic [NRD-1:0]    rd_busy_a;
      logic [NRD-1:0]    rd_busy_b;
      logic [DEPTH-1:0]  busy_a;
      logic [DEPTH-1:0]  busy_b;
   } exp_t;

   exp_t exp_q[$];

   // Reference state
   logic [WL-1:0]    regs_a [DEPTH];
   logic [WL-1:0]    regs_b [DEPTH];
   logic [DEPTH-1:0] busy_a;
   logic [DEPTH-1:0] busy_b;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
   endtask

   function automatic logic [AW-1:0] waddr(input int j);
      return wr_addr[j*AW +: AW];
   endfunction

   function automatic logic [WL-1:0] wdata(input int j);
      return wr_data[j*WL +: WL];
   endfunction

   // Expected outputs for the inputs currently on the bus.
   task automatic push_expect();
      exp_t e;
      for (int i = 0; i < NRD; i++) begin
         logic [AW-1:0] ra;
         logic [WL-1:0] da;
         logic          hit;
         ra  = rd_addr[i*AW +: AW];
         da  = regs_a[ra];
         hit = 1'b0;
         for (int j = 0; j < 2; j++) begin
            if (wr_en[j] && waddr(j) == ra) begin
               da  = wdata(j);
               hit = 1'b1;
            end
         end
         if (ra == 0) begin
            e.rd_data_a[i*WL +: WL] = '0;
            e.rd_data_b[i*WL +: WL] = '0;
            e.rd_busy_a[i]          = 1'b0;
            e.rd_busy_b[i]          = 1'b0;
         end else begin
            e.rd_data_a[i*WL +: WL] = da;
            e.rd_data_b[i*WL +: WL] = regs_b[ra];
            e.rd_busy_a[i]          = busy_a[ra] & ~hit;
            e.rd_busy_b[i]          = busy_b[ra];
         end
      end
      e.busy_a = busy_a;
      e.busy_b = busy_b;
      exp_q.push_back(e);
   endtask

   task automatic compare_pop();
      exp_t e;
      check("exp_queue_depth", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("a_rd_data", 64'(rd_data_a), 64'(e.rd_data_a));
         check("a_rd_busy", 64'(rd_busy_a), 64'(e.rd_busy_a));
         check("a_busy_vec", 64'(busy_vec_a), 64'(e.busy_a));
         check("b_rd_data", 64'(rd_data_b), 64'(e.rd_data_b));
         check("b_rd_busy", 64'(rd_busy_b), 64'(e.rd_busy_b));
         check("b_busy_vec", 64'(busy_vec_b), 64'(e.busy_b));
      end
   endtask

   // Advance the reference state across one rising edge.
   task automatic model_update();
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            regs_a[k] = '0;
            regs_b[k] = '0;
         end
         busy_a = '0;
         busy_b = '0;
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (wr_en[j]) begin
               if (waddr(j) != 0) regs_a[waddr(j)] = wdata(j);
               busy_a[waddr(j)] = 1'b0;
            end
         end
         if (wr_en[0]) begin
            if (waddr(0) != 0) regs_b[waddr(0)] = wdata(0);
            busy_b[waddr(0)] = 1'b0;
         end
         if (iss_en) begin
            busy_a[iss_addr] = 1'b1;
            busy_b[iss_addr] = 1'b1;
         end
         busy_a[0] = 1'b0;
         busy_b[0] = 1'b0;
      end
   endtask

   task automatic step(input logic r, input logic [1:0] we,
                       input logic [AW-1:0] wa0, input logic [WL-1:0] wd0,
                       input logic [AW-1:0] wa1, input logic [WL-1:0] wd1,
                       input logic ie, input logic [AW-1:0] ia,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      rst      = r;
      wr_en    = we;
      wr_addr  = {wa1, wa0};
      wr_data  = {wd1, wd0};
      iss_en   = ie;
      iss_addr = ia;
      rd_addr  = {ra1, ra0};
      push_expect();
      @(negedge clk);
      compare_pop();
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic idle_read(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      step(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, ra0, ra1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
      @(posedge clk);
      @(posedge clk);
      model_update();
      #1;

      // Reset state
      idle_read(5'd5, 5'd9);

      // Preload, then reset while a write and an issue are pending
      step(1'b0, 2'b01, 5'd5, 32'h0000_0055, 5'd0, 32'h0, 1'b1, 5'd6, 5'd5, 5'd9);
      step(1'b0, 2'b01, 5'd9, 32'h0000_0099, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9);
      step(1'b1, 2'b01, 5'd5, 32'h0000_DEAD, 5'd0, 32'h0, 1'b1, 5'd8, 5'd5, 5'd9);
      idle_read(5'd5, 5'd6);

      // Write/read bypass on r10 (a sees it now, b next cycle)
      step(1'b0, 2'b01, 5'd10, 32'h0000_00FF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd0);
      idle_read(5'd10, 5'd10);

      // Zero register: write and issue to r0
      step(1'b0, 2'b01, 5'd0, 32'h1234_5678, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
      idle_read(5'd0, 5'd10);

      // Scoreboard: issue r7, observe busy, write it back
      step(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd7);
      idle_read(5'd7, 5'd7);
      step(1'b0, 2'b01, 5'd7, 32'hA5A5_A5A5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7);
      idle_read(5'd7, 5'd7);

      // Simultaneous set and clear on r3
      step(1'b0, 2'b01, 5'd3, 32'h0000_CAFE, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
      idle_read(5'd3, 5'd0);

      // Dual write to r4: port 1 wins
      step(1'b0, 2'b11, 5'd4, 32'h0000_1111, 5'd4, 32'h0000_2222, 1'b0, 5'd0, 5'd4, 5'd4);
      idle_read(5'd4, 5'd4);

      // Port 1 alone hits a busy register
      step(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd12, 5'd12);
      step(1'b0, 2'b10, 5'd0, 32'h0, 5'd12, 32'h0BAD_F00D, 1'b0, 5'd0, 5'd12, 5'd4);
      idle_read(5'd12, 5'd12);

      // Random traffic over a small address window to force collisions
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 49) == 0),
              2'($urandom_range(0, 3)),
              5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Next-generation pipeline register file for the 5-stage core.
- Generalised to a parametrised depth, word length, read-port count and write-port count.
- Adds synchronous reset, an optional hardwired zero register, and same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard. The ID stage uses it to detect RAW hazards against in-flight writes.
- Sits between decode (read/issue) and writeback (write/clear).

Parameters:
- DEPTH, 32, number of registers; power of two, >= 2; AW = $clog2(DEPTH).
- WL, 32, word length in bits.
- NRD, 2, number of read ports, 1..4.
- NWR, 1, number of write ports, 1..2.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, 1 = read data reflects same-cycle write data.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*WL  read data; port i occupies bits [i*WL +: WL].
- rd_busy  out  NRD  port i's register has a pending write.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*WL  write data.
- iss_en  in  1  issue: mark iss_addr busy.
- iss_addr  in  AW  destination register of the issuing instruction.
- busy_vec  out  DEPTH  full scoreboard state.

Behaviour:
- Single clock domain. All state updates on the rising edge of clk.
- rst is synchronous and active-high, and has priority over every other input.
  - Edge with rst=1: all DEPTH registers := 0 and all busy bits := 0. Writes and issues in that cycle are dropped.
  - Reset mid-operation simply clears everything. No partial state survives.
- No initial-file loading. Contents are defined only by reset and writes.
- Write: on an edge with rst=0 and wr_en[j]=1, reg[wr_addr[j]] := wr_data[j].
  - Two write ports to the same address in one cycle: the higher index (port 1) wins.
  - ZERO_REG=1 and wr_addr=0: the write is discarded.
- Read: combinational, zero latency.
  - BYPASS=0: rd_data[i] = reg[rd_addr[i]].
  - BYPASS=1: if any wr_en[j] is set with wr_addr[j]==rd_addr[i], rd_data[i] = that wr_data[j] (highest j wins); otherwise it is the stored value.
  - ZERO_REG=1 and rd_addr[i]=0: rd_data[i] = 0 always, bypass included.
- Scoreboard, busy[DEPTH]:
  - Set: iss_en=1 sets busy[iss_addr].
  - Clear: wr_en[j]=1 clears busy[wr_addr[j]].
  - Same register set and cleared in one cycle: set wins, because a new producer replaces the retiring one.
  - Issue to an already-busy register: it stays busy. No count is kept; the single-issue in-order pipeline makes one bit sufficient.
  - A write to a non-busy register is legal and leaves busy at 0.
  - ZERO_REG=1: busy[0] is held at 0.
- rd_busy[i]:
  - BYPASS=1: rd_busy[i] = busy[rd_addr[i]] & ~(matching wr_en this cycle). A value being written now is ready via the bypass.
  - BYPASS=0: rd_busy[i] = busy[rd_addr[i]].
- Outputs after reset: rd_data = 0 on all ports (all registers zero); rd_busy = 0; busy_vec = 0.
- Widths: all addresses are AW bits, so every address value is in range and no wrap logic is needed.

Decomposition:
- Package rf_pkg:
  - AW helper function;
  - port-slice helper functions (addr_slice, data_slice);
  - ZERO_ADDR constant.
- One sub-module, rf_scoreboard:
  - ports: clk, rst, iss_en, iss_addr, NWR clear ports;
  - output: busy_vec;
  - owns all set/clear priority rules.
- The data array and the bypass muxes stay in regfile_mp.

Test Plan:
1. Reset: preload regs by writes, assert rst for 1 cycle while also driving wr_en=1 to r5 with 0xDEAD -> after the edge, all rd_data=0, busy_vec=0, and r5 reads 0.
2. Write/read with bypass: wr_en to r10 with 0x000000FF and rd_addr[0]=10 in the same cycle -> rd_data[0]=0xFF combinationally (BYPASS=1). Same with BYPASS=0 -> old value 0 that cycle, 0xFF after the edge.
3. Zero register: write 0x12345678 to r0, issue to r0 -> r0 reads 0 and busy_vec[0]=0.
4. Scoreboard: issue r7, then next cycle rd_addr[1]=7 -> rd_busy[1]=1. Write r7 with 0xA5A5A5A5 -> rd_busy[1]=0 in the write cycle (bypass) and busy_vec[7]=0 after the edge.
5. Simultaneous set/clear: iss_addr=3 and wr_addr=3 in the same cycle -> busy_vec[3]=1 after the edge, and reg3 holds the written data.
6. Dual write (NWR=2): both ports write r4, port 0 = 0x1111 and port 1 = 0x2222 -> r4=0x2222, and bypassed rd_data=0x2222 in that cycle.
